// File: rtl/p6_seq_datapath.sv
// p6_seq_datapath: register file, A/B operand registers, shifter, ALU,
// C result register and N/V/Z flags, driven by a built-in micro-sequencer
// (IDLE -> RDA -> RDB -> EXE -> WB). One op descriptor is accepted through
// an op_valid/op_ready handshake and completes with a one-cycle done pulse.
// Optional feature macro: P6_SEQ_DATAPATH_OPCOUNT_EN (completed-op counter).
module p6_seq_datapath #(
  parameter  int W     = 16,
  parameter  int NREGS = 8,
  localparam int RA    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [RA-1:0] op_rn,
  input  logic [RA-1:0] op_rm,
  input  logic [RA-1:0] op_rd,
  input  logic [1:0]    op_shift,
  input  logic [1:0]    op_aluop,
  input  logic          op_asel,
  input  logic          op_bsel,
  input  logic [W-1:0]  op_imm,
  input  logic [1:0]    op_vsel,
  input  logic          op_wb,
  input  logic          op_setf,
  input  logic [W-1:0]  mdata,
  input  logic [W-1:0]  pc,
  input  logic [RA-1:0] dbg_addr,
  output logic [W-1:0]  dbg_data,
  output logic [W-1:0]  dout,
  output logic          done,
  output logic          N_out,
  output logic          V_out,
  output logic          Z_out,
  output logic [15:0]   op_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RDA  = 3'd1,
    S_RDB  = 3'd2,
    S_EXE  = 3'd3,
    S_WB   = 3'd4
  } state_t;

  // Single-bit shifter; ASR keeps the sign bit.
  function automatic logic [W-1:0] shift_fn(input logic [W-1:0] x, input logic [1:0] sh);
    logic [W-1:0] r;
    case (sh)
      2'b00:   r = x;
      2'b01:   r = {x[W-2:0], 1'b0};
      2'b10:   r = {1'b0, x[W-1:1]};
      2'b11:   r = {x[W-1], x[W-1:1]};
      default: r = x;
    endcase
    return r;
  endfunction

  // ALU returning {signed_overflow, result}; overflow only meaningful for add/sub.
  function automatic logic [W:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [1:0] op);
    logic [W-1:0] r;
    logic         v;
    case (op)
      2'b00: begin
        r = a + b;
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      2'b01: begin
        r = a - b;
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      2'b10: begin
        r = a & b;
        v = 1'b0;
      end
      2'b11: begin
        r = ~b;
        v = 1'b0;
      end
      default: begin
        r = {W{1'b0}};
        v = 1'b0;
      end
    endcase
    return {v, r};
  endfunction

  state_t        state_q, state_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic [RA-1:0] rn_q, rn_d, rm_q, rm_d, rd_q, rd_d;
  logic [1:0]    shift_q, shift_d, aluop_q, aluop_d, vsel_q, vsel_d;
  logic          asel_q, asel_d, bsel_q, bsel_d, wb_q, wb_d, setf_q, setf_d;
  logic [W-1:0]  imm_q, imm_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, c_q, c_d;
  logic          n_q, n_d, v_q, v_d, z_q, z_d;
  logic [W-1:0]  rf_q [NREGS];
  logic [W-1:0]  rf_d [NREGS];

  logic [W-1:0]  ain_s, bin_s, wb_src_s;
  logic [W:0]    alu_s;

  // Sequencer: next state, descriptor capture and handshake/done outputs.
  always_comb begin
    state_d = state_q;
    rn_d    = rn_q;
    rm_d    = rm_q;
    rd_d    = rd_q;
    shift_d = shift_q;
    aluop_d = aluop_q;
    asel_d  = asel_q;
    bsel_d  = bsel_q;
    imm_d   = imm_q;
    vsel_d  = vsel_q;
    wb_d    = wb_q;
    setf_d  = setf_q;
    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          state_d = S_RDA;
          rn_d    = op_rn;
          rm_d    = op_rm;
          rd_d    = op_rd;
          shift_d = op_shift;
          aluop_d = op_aluop;
          asel_d  = op_asel;
          bsel_d  = op_bsel;
          imm_d   = op_imm;
          vsel_d  = op_vsel;
          wb_d    = op_wb;
          setf_d  = op_setf;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RDA:   state_d = S_RDB;
      S_RDB:   state_d = S_EXE;
      S_EXE:   state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Ready is registered so it is high in the done cycle for back-to-back accepts.
    ready_d = (state_d == S_IDLE);
    done_d  = (state_q == S_WB);
  end

  // Datapath: operand muxes, ALU and write-back source selection.
  always_comb begin
    ain_s = asel_q ? {W{1'b0}} : a_q;
    bin_s = bsel_q ? imm_q : shift_fn(b_q, shift_q);
    alu_s = alu_fn(ain_s, bin_s, aluop_q);
    case (vsel_q)
      2'b00:   wb_src_s = c_q;
      2'b01:   wb_src_s = imm_q;
      2'b10:   wb_src_s = mdata;
      2'b11:   wb_src_s = pc;
      default: wb_src_s = c_q;
    endcase
  end

  // Per-state register updates: operand loads, result/flags, register write-back.
  always_comb begin
    a_d  = a_q;
    b_d  = b_q;
    c_d  = c_q;
    n_d  = n_q;
    v_d  = v_q;
    z_d  = z_q;
    rf_d = rf_q;
    if (state_q == S_RDA) begin
      a_d = rf_q[rn_q];
    end else if (state_q == S_RDB) begin
      b_d = rf_q[rm_q];
    end else if (state_q == S_EXE) begin
      c_d = alu_s[W-1:0];
      if (setf_q) begin
        n_d = alu_s[W-1];
        v_d = alu_s[W];
        z_d = (alu_s[W-1:0] == {W{1'b0}});
      end else begin
        n_d = n_q;
      end
    end else if ((state_q == S_WB) && wb_q) begin
      rf_d[rd_q] = wb_src_s;
    end else begin
      a_d = a_q;
    end
  end

  // State, descriptor, datapath and register-file flops with async clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      rn_q    <= {RA{1'b0}};
      rm_q    <= {RA{1'b0}};
      rd_q    <= {RA{1'b0}};
      shift_q <= 2'b00;
      aluop_q <= 2'b00;
      asel_q  <= 1'b0;
      bsel_q  <= 1'b0;
      imm_q   <= {W{1'b0}};
      vsel_q  <= 2'b00;
      wb_q    <= 1'b0;
      setf_q  <= 1'b0;
      a_q     <= {W{1'b0}};
      b_q     <= {W{1'b0}};
      c_q     <= {W{1'b0}};
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= {W{1'b0}};
      end
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      rn_q    <= rn_d;
      rm_q    <= rm_d;
      rd_q    <= rd_d;
      shift_q <= shift_d;
      aluop_q <= aluop_d;
      asel_q  <= asel_d;
      bsel_q  <= bsel_d;
      imm_q   <= imm_d;
      vsel_q  <= vsel_d;
      wb_q    <= wb_d;
      setf_q  <= setf_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      n_q     <= n_d;
      v_q     <= v_d;
      z_q     <= z_d;
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  assign op_ready = ready_q;
  assign done     = done_q;
  assign dout     = c_q;
  assign N_out    = n_q;
  assign V_out    = v_q;
  assign Z_out    = z_q;
  assign dbg_data = rf_q[dbg_addr];

`ifdef P6_SEQ_DATAPATH_OPCOUNT_EN
  logic [15:0] op_count_q, op_count_d;

  // Count every completed op (WB edge), wrapping at 16 bits.
  always_comb begin
    if (state_q == S_WB) begin
      op_count_d = op_count_q + 16'd1;
    end else begin
      op_count_d = op_count_q;
    end
  end

  // Completed-op counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q <= 16'd0;
    end else begin
      op_count_q <= op_count_d;
    end
  end

  assign op_count = op_count_q;
`else
  assign op_count = 16'd0;
`endif

endmodule

// File: tb/tb_p6_seq_datapath.sv
// Scoreboard bench for p6_seq_datapath: the driver pushes hand-computed
// expectations per op; a monitor pops and compares on every done pulse.
module tb_p6_seq_datapath;

  typedef struct {
    logic [15:0] dout;
    logic [2:0]  nvz;
    logic [2:0]  addr;
    logic [15:0] val;
    int          acc_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [2:0]  op_rn = 3'd0, op_rm = 3'd0, op_rd = 3'd0;
  logic [1:0]  op_shift = 2'd0, op_aluop = 2'd0, op_vsel = 2'd0;
  logic        op_asel = 1'b0, op_bsel = 1'b0, op_wb = 1'b0, op_setf = 1'b0;
  logic [15:0] op_imm = 16'd0, mdata = 16'd0, pc = 16'd0;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data, dout, op_count;
  logic        done, N_out, V_out, Z_out;

  logic [2:0]  drv_addr = 3'd0;
  logic [2:0]  mon_addr = 3'd0;
  logic        mon_active = 1'b0;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  exp_t        q[$];

  assign dbg_addr = mon_active ? mon_addr : drv_addr;

  p6_seq_datapath dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .op_rn(op_rn), .op_rm(op_rm), .op_rd(op_rd), .op_shift(op_shift),
    .op_aluop(op_aluop), .op_asel(op_asel), .op_bsel(op_bsel), .op_imm(op_imm),
    .op_vsel(op_vsel), .op_wb(op_wb), .op_setf(op_setf), .mdata(mdata), .pc(pc),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dout(dout), .done(done),
    .N_out(N_out), .V_out(V_out), .Z_out(Z_out), .op_count(op_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Issue one op: wait for ready, present fields for one accept edge, push expectation.
  task automatic issue(input logic [2:0] rn, input logic [2:0] rm, input logic [2:0] rd,
                       input logic [1:0] sh, input logic [1:0] alu,
                       input logic asel, input logic bsel, input logic [15:0] imm,
                       input logic [1:0] vsel, input logic wb, input logic setf,
                       input logic [15:0] md, input logic [15:0] pcv,
                       input logic [15:0] e_dout, input logic [2:0] e_nvz,
                       input logic [2:0] e_addr, input logic [15:0] e_val);
    exp_t e;
    int b;
    b = 0;
    while (op_ready !== 1'b1 && b < 20) begin
      @(posedge clk); #1;
      b++;
    end
    chk("op_ready_wait", {31'd0, op_ready}, 32'd1);
    op_rn = rn; op_rm = rm; op_rd = rd; op_shift = sh; op_aluop = alu;
    op_asel = asel; op_bsel = bsel; op_imm = imm; op_vsel = vsel;
    op_wb = wb; op_setf = setf; mdata = md; pc = pcv;
    op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    e.dout = e_dout; e.nvz = e_nvz; e.addr = e_addr; e.val = e_val; e.acc_cyc = cyc;
    q.push_back(e);
    for (int i = 0; i < 4; i++) begin
      chk("op_ready_busy", {31'd0, op_ready}, 32'd0);
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (q.size() != 0 && b < 50) begin
      @(posedge clk); #1;
      b++;
    end
    chk("queue_drain", q.size(), 32'd0);
  endtask

  // Monitor: on each done pulse pop the next expectation and compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && done === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_done", {31'd0, done}, 32'd0);
        end else begin
          e = q.pop_front();
          mon_addr = e.addr;
          mon_active = 1'b1;
          #1;
          chk("done_latency", cyc - e.acc_cyc, 32'd4);
          chk("dout", {16'd0, dout}, {16'd0, e.dout});
          chk("flags_nvz", {29'd0, N_out, V_out, Z_out}, {29'd0, e.nvz});
          chk("reg_readback", {16'd0, dbg_data}, {16'd0, e.val});
          mon_active = 1'b0;
        end
      end
    end
  end

  initial begin
    // Reset for two cycles, then check the cleared state.
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rst_dout", {16'd0, dout}, 32'd0);
    chk("rst_flags", {29'd0, N_out, V_out, Z_out}, 32'd0);
    chk("rst_ready", {31'd0, op_ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_opcount", {16'd0, op_count}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      drv_addr = i[2:0]; #1;
      chk("rst_reg", {16'd0, dbg_data}, 32'd0);
    end
    @(posedge clk); #1;

    //     rn    rm    rd    sh     alu    as    bs    imm        vs     wb    sf    mdata      pc        dout       nvz     addr  val
    issue(3'd0, 3'd0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 16'h0007, 2'd1, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 3'b000, 3'd0, 16'h0007);
    issue(3'd0, 3'd0, 3'd1, 2'd0, 2'd0, 1'b0, 1'b0, 16'h0002, 2'd1, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h000E, 3'b000, 3'd1, 16'h0002);
    issue(3'd0, 3'd1, 3'd2, 2'd1, 2'd0, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h000B, 3'b000, 3'd2, 16'h000B);
    issue(3'd0, 3'd0, 3'd3, 2'd0, 2'd0, 1'b1, 1'b1, 16'h7FFF, 2'd1, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h7FFF, 3'b000, 3'd3, 16'h7FFF);
    issue(3'd0, 3'd0, 3'd4, 2'd0, 2'd0, 1'b1, 1'b1, 16'hFFFF, 2'd1, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, 3'b000, 3'd4, 16'hFFFF);
    // CMP with signed overflow, no write-back (R5 stays 0).
    issue(3'd3, 3'd4, 3'd5, 2'd0, 2'd1, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h8000, 3'b110, 3'd5, 16'h0000);
    // Back-to-back: AND with flags, memory data write-back.
    issue(3'd4, 3'd4, 3'd5, 2'd0, 2'd2, 1'b0, 1'b0, 16'h0000, 2'd2, 1'b1, 1'b1, 16'hBEEF, 16'h0000, 16'hFFFF, 3'b100, 3'd5, 16'hBEEF);
    // ASR of positive then NOT-B; pc write-back.
    issue(3'd0, 3'd3, 3'd6, 2'd3, 2'd3, 1'b0, 1'b0, 16'h0000, 2'd3, 1'b1, 1'b1, 16'h0000, 16'h1234, 16'hC000, 3'b100, 3'd6, 16'h1234);
    // Zero result sets Z.
    issue(3'd1, 3'd1, 3'd6, 2'd0, 2'd1, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 3'b001, 3'd6, 16'h1234);
    // LSR of 0xFFFF then add: positive overflow.
    issue(3'd2, 3'd4, 3'd7, 2'd2, 2'd0, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h800A, 3'b110, 3'd7, 16'h800A);
    // ASR replicates sign of 0xBEEF -> 0xDF77, NOT-B -> 0x2088.
    issue(3'd0, 3'd5, 3'd7, 2'd3, 2'd3, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h2088, 3'b000, 3'd7, 16'h800A);
    drain();

`ifdef P6_SEQ_DATAPATH_OPCOUNT_EN
    chk("opcount_completed", {16'd0, op_count}, 32'd11);
`else
    chk("opcount_tied", {16'd0, op_count}, 32'd0);
`endif

    // Reset mid-op: write to R6 with flags, abort in EXE.
    op_rn = 3'd0; op_rm = 3'd0; op_rd = 3'd6; op_shift = 2'd0; op_aluop = 2'd0;
    op_asel = 1'b1; op_bsel = 1'b1; op_imm = 16'h8000; op_vsel = 2'd1;
    op_wb = 1'b1; op_setf = 1'b1;
    op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("abort_no_done", {31'd0, done}, 32'd0);
      @(posedge clk); #1;
    end
    drv_addr = 3'd6; #1;
    chk("abort_r6", {16'd0, dbg_data}, 32'd0);
    drv_addr = 3'd2; #1;
    chk("abort_r2_cleared", {16'd0, dbg_data}, 32'd0);
    chk("abort_flags", {29'd0, N_out, V_out, Z_out}, 32'd0);
    chk("abort_dout", {16'd0, dout}, 32'd0);
    chk("abort_opcount", {16'd0, op_count}, 32'd0);
    chk("abort_ready", {31'd0, op_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
